// File: rtl/otter_pkg.sv
// Shared Otter pipeline types and constants used by hazard and stall logic.
package otter_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    LU_STALL = 1'b1
  } stall_state_t;

  localparam int LU_W = 4;

  localparam logic [6:0] OPCODE_LOAD = 7'b0000011;

endpackage

// File: rtl/pipeline_stall_ctrl_sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Turns hazard and memory-wait signals into per-stage enables, bubble
// controls and PC write enable for the 5-stage Otter pipeline.
module pipeline_stall_ctrl
  import otter_pkg::*;
#(
  parameter int LU_CYCLES = 1,
  parameter int CNT_W     = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             load_use_haz,
  input  logic             control_haz,
  input  logic             imem_stall,
  input  logic             dmem_stall,
  output logic             pc_write,
  output logic             if_de_en,
  output logic             de_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_de_flush,
  output logic             de_ex_flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  // The first bubble cycle is spent in RUN, so the countdown covers the rest.
  localparam logic [LU_W-1:0] LU_INIT = LU_W'(LU_CYCLES - 1);

  stall_state_t    state_q, state_d;
  logic [LU_W-1:0] lu_left_q, lu_left_d;
  logic            stall_inc, flush_inc;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= RUN;
      lu_left_q <= '0;
    end else begin
      state_q   <= state_d;
      lu_left_q <= lu_left_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    lu_left_d = lu_left_q;
    if (dmem_stall) begin
      state_d   = state_q;
      lu_left_d = lu_left_q;
    end else if (control_haz) begin
      state_d   = RUN;
      lu_left_d = '0;
    end else if (state_q == LU_STALL) begin
      lu_left_d = lu_left_q - 1'b1;
      if (lu_left_q <= 4'd1) begin
        state_d   = RUN;
        lu_left_d = '0;
      end
    end else if (load_use_haz && (LU_CYCLES > 1)) begin
      state_d   = LU_STALL;
      lu_left_d = LU_INIT;
    end
  end

  always_comb begin
    pc_write    = 1'b1;
    if_de_en    = 1'b1;
    de_ex_en    = 1'b1;
    ex_mem_en   = 1'b1;
    mem_wb_en   = 1'b1;
    if_de_flush = 1'b0;
    de_ex_flush = 1'b0;
    if (RST) begin
      pc_write    = 1'b0;
      if_de_en    = 1'b0;
      de_ex_en    = 1'b0;
      ex_mem_en   = 1'b0;
      mem_wb_en   = 1'b0;
      if_de_flush = 1'b1;
      de_ex_flush = 1'b1;
    end else if (dmem_stall) begin
      pc_write  = 1'b0;
      if_de_en  = 1'b0;
      de_ex_en  = 1'b0;
      ex_mem_en = 1'b0;
      mem_wb_en = 1'b0;
    end else if (control_haz) begin
      if_de_flush = 1'b1;
      de_ex_flush = 1'b1;
    end else if ((state_q == LU_STALL) || load_use_haz) begin
      // Hold PC and IF/DE, push a bubble into EX while older work drains.
      pc_write    = 1'b0;
      if_de_en    = 1'b0;
      de_ex_flush = 1'b1;
    end else if (imem_stall) begin
      pc_write    = 1'b0;
      if_de_flush = 1'b1;
    end
  end

  assign stall_inc = !RST && !pc_write;
  assign flush_inc = !RST && !dmem_stall && control_haz;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .CLK (CLK),
    .RST (RST),
    .inc (stall_inc),
    .cnt (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .CLK (CLK),
    .RST (RST),
    .inc (flush_inc),
    .cnt (flush_cnt)
  );

  a_flush_in_reset: assert property (@(posedge CLK) RST |-> (if_de_flush || de_ex_flush));
  a_pc_hold_with_if_de: assert property (@(posedge CLK) !if_de_en |-> !pc_write);

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed bench: two controller instances (LU_CYCLES=1/CNT_W=4 and LU_CYCLES=3/CNT_W=32).
module tb_pipeline_stall_ctrl;

  // Control vector order: {pc_write, if_de_en, de_ex_en, ex_mem_en, mem_wb_en, if_de_flush, de_ex_flush}
  localparam logic [6:0] V_NORMAL = 7'b1111100;
  localparam logic [6:0] V_BUBBLE = 7'b0011101;
  localparam logic [6:0] V_FREEZE = 7'b0000000;
  localparam logic [6:0] V_CTRL   = 7'b1111111;
  localparam logic [6:0] V_IMEM   = 7'b0111110;
  localparam logic [6:0] V_RESET  = 7'b0000011;

  logic clk, rst;
  logic load_use_haz, control_haz, imem_stall, dmem_stall;

  logic        pw_a, ide_a, dex_a, exm_a, mwb_a, ifl_a, dfl_a;
  logic [3:0]  stall_cnt_a, flush_cnt_a;
  logic        pw_b, ide_b, dex_b, exm_b, mwb_b, ifl_b, dfl_b;
  logic [31:0] stall_cnt_b, flush_cnt_b;
  logic [6:0]  ctl_a, ctl_b;

  int compared;
  int mismatched;

  assign ctl_a = {pw_a, ide_a, dex_a, exm_a, mwb_a, ifl_a, dfl_a};
  assign ctl_b = {pw_b, ide_b, dex_b, exm_b, mwb_b, ifl_b, dfl_b};

  pipeline_stall_ctrl #(.LU_CYCLES(1), .CNT_W(4)) dut_a (
    .CLK(clk), .RST(rst),
    .load_use_haz(load_use_haz), .control_haz(control_haz),
    .imem_stall(imem_stall), .dmem_stall(dmem_stall),
    .pc_write(pw_a), .if_de_en(ide_a), .de_ex_en(dex_a),
    .ex_mem_en(exm_a), .mem_wb_en(mwb_a),
    .if_de_flush(ifl_a), .de_ex_flush(dfl_a),
    .stall_cnt(stall_cnt_a), .flush_cnt(flush_cnt_a)
  );

  pipeline_stall_ctrl #(.LU_CYCLES(3), .CNT_W(32)) dut_b (
    .CLK(clk), .RST(rst),
    .load_use_haz(load_use_haz), .control_haz(control_haz),
    .imem_stall(imem_stall), .dmem_stall(dmem_stall),
    .pc_write(pw_b), .if_de_en(ide_b), .de_ex_en(dex_b),
    .ex_mem_en(exm_b), .mem_wb_en(mwb_b),
    .if_de_flush(ifl_b), .de_ex_flush(dfl_b),
    .stall_cnt(stall_cnt_b), .flush_cnt(flush_cnt_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Steps end 1 time unit after a rising edge; outputs are checked on the falling edge.
  task automatic next_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic lu, input logic ch, input logic im, input logic dm);
    load_use_haz = lu;
    control_haz  = ch;
    imem_stall   = im;
    dmem_stall   = dm;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    next_edge();
    next_edge();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    compared++;
    if (ctl_b !== V_BUBBLE) begin
      mismatched++;
      $display("[TB] FAIL reset_pre_lu: got %b expected %b", ctl_b, V_BUBBLE);
    end
    next_edge();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    compared++;
    if (ctl_b !== V_BUBBLE) begin
      mismatched++;
      $display("[TB] FAIL reset_in_lu_stall: got %b expected %b", ctl_b, V_BUBBLE);
    end
    rst = 1'b1;
    #1;
    compared++;
    if (ctl_b !== V_RESET) begin
      mismatched++;
      $display("[TB] FAIL reset_async_outputs: got %b expected %b", ctl_b, V_RESET);
    end
    next_edge();
    rst = 1'b0;
    @(negedge clk);
    compared++;
    if (ctl_b !== V_NORMAL) begin
      mismatched++;
      $display("[TB] FAIL reset_release_run: got %b expected %b", ctl_b, V_NORMAL);
    end
    compared++;
    if (stall_cnt_b !== 32'd0 || flush_cnt_b !== 32'd0) begin
      mismatched++;
      $display("[TB] FAIL reset_counters: got stall=%0d flush=%0d expected 0/0", stall_cnt_b, flush_cnt_b);
    end
    next_edge();
  endtask

  task automatic test_load_use_1();
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    compared++;
    if (ctl_a !== V_BUBBLE) begin
      mismatched++;
      $display("[TB] FAIL lu1_bubble: got %b expected %b", ctl_a, V_BUBBLE);
    end
    next_edge();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    compared++;
    if (ctl_a !== V_NORMAL) begin
      mismatched++;
      $display("[TB] FAIL lu1_resume: got %b expected %b", ctl_a, V_NORMAL);
    end
    next_edge();
    compared++;
    if (stall_cnt_a !== 4'd1) begin
      mismatched++;
      $display("[TB] FAIL lu1_stall_cnt: got %0d expected 1", stall_cnt_a);
    end
  endtask

  task automatic test_load_use_3();
    logic [6:0] exp_seq [4];
    exp_seq[0] = V_BUBBLE;
    exp_seq[1] = V_BUBBLE;
    exp_seq[2] = V_BUBBLE;
    exp_seq[3] = V_NORMAL;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive((i == 0), 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      compared++;
      if (ctl_b !== exp_seq[i]) begin
        mismatched++;
        $display("[TB] FAIL lu3_cycle%0d: got %b expected %b", i, ctl_b, exp_seq[i]);
      end
      next_edge();
    end
    compared++;
    if (stall_cnt_b !== 32'd3) begin
      mismatched++;
      $display("[TB] FAIL lu3_stall_cnt: got %0d expected 3", stall_cnt_b);
    end
  endtask

  task automatic test_ctrl_over_lu();
    do_reset();
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    compared++;
    if (ctl_b !== V_CTRL) begin
      mismatched++;
      $display("[TB] FAIL ctrl_lu_same_cycle: got %b expected %b", ctl_b, V_CTRL);
    end
    next_edge();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    compared++;
    if (ctl_b !== V_NORMAL) begin
      mismatched++;
      $display("[TB] FAIL ctrl_no_stall_after: got %b expected %b", ctl_b, V_NORMAL);
    end
    compared++;
    if (flush_cnt_b !== 32'd1 || stall_cnt_b !== 32'd0) begin
      mismatched++;
      $display("[TB] FAIL ctrl_counters: got flush=%0d stall=%0d expected 1/0", flush_cnt_b, stall_cnt_b);
    end
    next_edge();
  endtask

  task automatic test_dmem_in_lu();
    logic [6:0] exp_seq [8];
    logic       dm_seq  [8];
    for (int i = 0; i < 8; i++) begin
      dm_seq[i]  = (i >= 1 && i <= 4);
      exp_seq[i] = dm_seq[i] ? V_FREEZE : V_BUBBLE;
    end
    exp_seq[7] = V_NORMAL;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive((i == 0), 1'b0, 1'b0, dm_seq[i]);
      @(negedge clk);
      compared++;
      if (ctl_b !== exp_seq[i]) begin
        mismatched++;
        $display("[TB] FAIL dmem_lu_cycle%0d: got %b expected %b", i, ctl_b, exp_seq[i]);
      end
      next_edge();
    end
    compared++;
    if (stall_cnt_b !== 32'd7 || flush_cnt_b !== 32'd0) begin
      mismatched++;
      $display("[TB] FAIL dmem_lu_counters: got stall=%0d flush=%0d expected 7/0", stall_cnt_b, flush_cnt_b);
    end
  endtask

  task automatic test_priority();
    do_reset();
    drive(1'b1, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    compared++;
    if (ctl_b !== V_FREEZE) begin
      mismatched++;
      $display("[TB] FAIL prio_dmem_over_ctrl: got %b expected %b", ctl_b, V_FREEZE);
    end
    next_edge();
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    compared++;
    if (ctl_b !== V_BUBBLE) begin
      mismatched++;
      $display("[TB] FAIL prio_lu_over_imem: got %b expected %b", ctl_b, V_BUBBLE);
    end
    next_edge();
    compared++;
    if (flush_cnt_b !== 32'd0 || stall_cnt_b !== 32'd2) begin
      mismatched++;
      $display("[TB] FAIL prio_counters: got flush=%0d stall=%0d expected 0/2", flush_cnt_b, stall_cnt_b);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      compared++;
      if (ctl_a !== V_IMEM) begin
        mismatched++;
        $display("[TB] FAIL sat_imem_cycle%0d: got %b expected %b", i, ctl_a, V_IMEM);
      end
      next_edge();
    end
    compared++;
    if (stall_cnt_a !== 4'd15) begin
      mismatched++;
      $display("[TB] FAIL sat_stall_cnt: got %0d expected 15", stall_cnt_a);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    compared++;
    if (ctl_a !== V_NORMAL) begin
      mismatched++;
      $display("[TB] FAIL sat_resume: got %b expected %b", ctl_a, V_NORMAL);
    end
    next_edge();
    compared++;
    if (stall_cnt_a !== 4'd15) begin
      mismatched++;
      $display("[TB] FAIL sat_hold: got %0d expected 15", stall_cnt_a);
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst        = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    test_reset();
    test_load_use_1();
    test_load_use_3();
    test_ctrl_over_lu();
    test_dmem_in_lu();
    test_priority();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
